// File: rtl/mem_test_run_ctrl.sv
// Sequences memory-test engine passes: reset gap, release, wait for done or watchdog, tally results.
// All outputs registered (1-cycle latency from sampled test_done); no backpressure, en only gates new passes.
module mem_test_run_ctrl #(
  parameter int unsigned NUM_RUNS       = 0,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 test_rst_n,
  input  logic                 test_done,
  input  logic                 test_pass,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] run_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic                 first_fail_vld,
  output logic [CNT_WIDTH-1:0] first_fail_run,
  output logic                 timeout_err,
  output logic                 all_done,
  output logic                 status_ok
);

  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RUNS_TGT = CNT_WIDTH'(NUM_RUNS);
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]      WD_ONE   = WD_W'(1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {IDLE, GAP, WAIT, HALT} state_t;

  state_t               state;
  logic [GAP_W-1:0]     gap_cnt;
  logic [WD_W-1:0]      wd_cnt;

  logic                 pass_end;
  logic                 pass_fail;
  logic [CNT_WIDTH-1:0] run_nxt;
  logic [CNT_WIDTH-1:0] fail_nxt;

  // A done seen on the watchdog's last cycle still counts as a real result.
  assign pass_end  = (state == WAIT) && (test_done || (wd_cnt == WD_LAST));
  assign pass_fail = test_done ? !test_pass : 1'b1;
  assign run_nxt   = (run_cnt  == CNT_MAX) ? run_cnt  : run_cnt  + CNT_ONE;
  assign fail_nxt  = (fail_cnt == CNT_MAX) ? fail_cnt : fail_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      wd_cnt         <= '0;
      test_rst_n     <= 1'b0;
      busy           <= 1'b0;
      run_cnt        <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_run <= '0;
      timeout_err    <= 1'b0;
      all_done       <= 1'b0;
      status_ok      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state   <= GAP;
            gap_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_ONE;
          if (gap_cnt == GAP_LAST) begin
            state      <= WAIT;
            wd_cnt     <= '0;
            test_rst_n <= 1'b1;
          end
        end
        WAIT: begin
          wd_cnt <= wd_cnt + WD_ONE;
          if (pass_end) begin
            test_rst_n <= 1'b0;
            run_cnt    <= run_nxt;
            status_ok  <= (fail_cnt == '0) && !pass_fail;
            if (pass_fail) begin
              fail_cnt <= fail_nxt;
              if (!first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_run <= run_cnt;
              end
            end
            if (!test_done) begin
              timeout_err <= 1'b1;
            end
            if ((NUM_RUNS != 0) && (run_nxt == RUNS_TGT)) begin
              state    <= HALT;
              busy     <= 1'b0;
              all_done <= 1'b1;
            end else if (en) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
